// File: rtl/fpu_csr_ctx_pkg.sv
// Shared constants for the multi-context FPU CSR file: CSR addresses, op and rounding-mode
// encodings, exception flag bit positions.
package fpu_csr_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  localparam int FLAG_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } csr_state_e;

  function automatic logic rm_reserved(input logic [2:0] rm);
    return rm > RM_RMM;
  endfunction

endpackage

// File: rtl/fpu_csr_ctx_if.sv
// CSR request/response channel: valid/ready request, registered valid/ready response.
interface fpu_csr_ctx_if #(
  parameter int CTX_W = 1,
  parameter int XLEN  = 32
);
  logic             csr_req_valid;
  logic             csr_req_ready;
  logic [CTX_W-1:0] csr_ctx;
  logic [1:0]       csr_op;
  logic [11:0]      csr_addr;
  logic [XLEN-1:0]  csr_wdata;
  logic             csr_rsp_valid;
  logic             csr_rsp_ready;
  logic [XLEN-1:0]  csr_rsp_rdata;
  logic             csr_rsp_illegal;

  modport master (
    output csr_req_valid, csr_ctx, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_illegal
  );

  modport slave (
    input  csr_req_valid, csr_ctx, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_illegal
  );
endinterface

// File: rtl/fpu_csr_ctx_flag_accum.sv
// Per-context OR of exception flags from all retire ports this cycle; purely combinational.
// Retires tagged with a context outside 0..NUM_CTX-1 match no slot and are dropped.
module fpu_flag_accum
  import fpu_csr_pkg::*;
#(
  parameter int NUM_CTX   = 2,
  parameter int NUM_PORTS = 2,
  parameter int CTX_W     = 1
) (
  input  logic [NUM_PORTS-1:0]              fpu_done,
  input  logic [NUM_PORTS*CTX_W-1:0]        fpu_done_ctx,
  input  logic [NUM_PORTS*FLAG_W-1:0]       fpu_done_flags,
  output logic [NUM_CTX-1:0][FLAG_W-1:0]    accrued
);

  always_comb begin
    accrued = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fpu_done[p] && (32'(fpu_done_ctx[p*CTX_W +: CTX_W]) == c)) begin
          accrued[c] = accrued[c] | fpu_done_flags[p*FLAG_W +: FLAG_W];
        end
      end
    end
  end

endmodule

// File: rtl/fpu_csr_ctx.sv
// Multi-context fflags/frm/fcsr file: 1-cycle registered CSR response held until consumed (2-cycle min
// throughput), per-cycle flag accrual, 1-cycle dynamic rm resolution. Optional FPU_CSR_DIRTY_EN dirty bits.
module fpu_csr_ctx
  import fpu_csr_pkg::*;
#(
  parameter int NUM_CTX   = 2,
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  localparam int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  fpu_csr_ctx_if.slave                 csr,
  input  logic [NUM_PORTS-1:0]         fpu_done,
  input  logic [NUM_PORTS*CTX_W-1:0]   fpu_done_ctx,
  input  logic [NUM_PORTS*FLAG_W-1:0]  fpu_done_flags,
  input  logic                         fpu_issue_valid,
  input  logic [CTX_W-1:0]             fpu_issue_ctx,
  input  logic [2:0]                   fpu_issue_rm,
`ifdef FPU_CSR_DIRTY_EN
  output logic [NUM_CTX-1:0]           fs_dirty,
  input  logic [NUM_CTX-1:0]           fs_clean,
`endif
  output logic                         fpu_rm_valid,
  output logic [2:0]                   fpu_rm,
  output logic                         fpu_rm_illegal
);

  csr_state_e state_q, state_d;

  logic [FLAG_W-1:0] fflags_q [NUM_CTX];
  logic [FLAG_W-1:0] fflags_d [NUM_CTX];
  logic [2:0]        frm_q    [NUM_CTX];
  logic [2:0]        frm_d    [NUM_CTX];

  logic [NUM_CTX-1:0][FLAG_W-1:0] accrued;

  csr_op_e     op;
  logic        accept, ctx_ok, addr_ok, legal, wr_en;
  logic [FLAG_W-1:0] sel_fflags;
  logic [2:0]  sel_frm;
  logic [7:0]  old_val, new_val;
  logic [XLEN-1:0] rsp_rdata_q;
  logic        rsp_illegal_q;
  logic        unused_wdata_hi;

  fpu_flag_accum #(
    .NUM_CTX   (NUM_CTX),
    .NUM_PORTS (NUM_PORTS),
    .CTX_W     (CTX_W)
  ) u_accum (
    .fpu_done       (fpu_done),
    .fpu_done_ctx   (fpu_done_ctx),
    .fpu_done_flags (fpu_done_flags),
    .accrued        (accrued)
  );

  // Only the low byte of wdata can reach any field; fcsr is the widest view.
  assign unused_wdata_hi = ^csr.csr_wdata[XLEN-1:8];

  always_comb begin
    op      = csr_op_e'(csr.csr_op);
    ctx_ok  = 32'(csr.csr_ctx) < NUM_CTX;
    addr_ok = (csr.csr_addr == CSR_FFLAGS) || (csr.csr_addr == CSR_FRM) ||
              (csr.csr_addr == CSR_FCSR);
    legal   = ctx_ok && addr_ok;
    accept  = (state_q == ST_IDLE) && csr.csr_req_valid;
    wr_en   = accept && legal && (op != OP_READ);

    sel_fflags = '0;
    sel_frm    = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (32'(csr.csr_ctx) == c) begin
        sel_fflags = fflags_q[c];
        sel_frm    = frm_q[c];
      end
    end

    old_val = '0;
    if (csr.csr_addr == CSR_FFLAGS) old_val = {3'b000, sel_fflags};
    else if (csr.csr_addr == CSR_FRM) old_val = {5'b00000, sel_frm};
    else if (csr.csr_addr == CSR_FCSR) old_val = {sel_frm, sel_fflags};

    case (op)
      OP_RW:   new_val = csr.csr_wdata[7:0];
      OP_RS:   new_val = old_val | csr.csr_wdata[7:0];
      OP_RC:   new_val = old_val & ~csr.csr_wdata[7:0];
      default: new_val = old_val;
    endcase
  end

  // Accrued flags are OR'd after the CSR write so a same-cycle clear never loses a retire.
  always_comb begin
    for (int c = 0; c < NUM_CTX; c++) begin
      fflags_d[c] = fflags_q[c] | accrued[c];
      frm_d[c]    = frm_q[c];
      if (wr_en && (32'(csr.csr_ctx) == c)) begin
        if (csr.csr_addr == CSR_FFLAGS) begin
          fflags_d[c] = new_val[FLAG_W-1:0] | accrued[c];
        end else if (csr.csr_addr == CSR_FRM) begin
          frm_d[c] = new_val[2:0];
        end else begin
          frm_d[c]    = new_val[7:5];
          fflags_d[c] = new_val[FLAG_W-1:0] | accrued[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        fflags_q[c] <= '0;
        frm_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        fflags_q[c] <= fflags_d[c];
        frm_q[c]    <= frm_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (csr.csr_req_valid) state_d = ST_RESP;
      ST_RESP: if (csr.csr_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else if (accept) begin
      rsp_rdata_q   <= legal ? {{(XLEN-8){1'b0}}, old_val} : '0;
      rsp_illegal_q <= !legal;
    end
  end

  assign csr.csr_req_ready   = (state_q == ST_IDLE);
  assign csr.csr_rsp_valid   = (state_q == ST_RESP);
  assign csr.csr_rsp_rdata   = rsp_rdata_q;
  assign csr.csr_rsp_illegal = rsp_illegal_q;

  logic [2:0] issue_frm, rm_res;
  logic       rm_bad;

  // Resolution reads frm_q, i.e. the value before any CSR write landing this same edge.
  always_comb begin
    issue_frm = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (32'(fpu_issue_ctx) == c) issue_frm = frm_q[c];
    end
    rm_res = (fpu_issue_rm == RM_DYN) ? issue_frm : fpu_issue_rm;
    rm_bad = rm_reserved(rm_res) || !(32'(fpu_issue_ctx) < NUM_CTX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_rm_valid   <= 1'b0;
      fpu_rm         <= '0;
      fpu_rm_illegal <= 1'b0;
    end else begin
      fpu_rm_valid   <= fpu_issue_valid;
      fpu_rm         <= (fpu_issue_valid && !rm_bad) ? rm_res : 3'b000;
      fpu_rm_illegal <= fpu_issue_valid && rm_bad;
    end
  end

`ifdef FPU_CSR_DIRTY_EN
  logic [NUM_CTX-1:0] dirty_q, dirty_set;

  always_comb begin
    for (int c = 0; c < NUM_CTX; c++) begin
      dirty_set[c] = (|accrued[c]) ||
                     (wr_en && (32'(csr.csr_ctx) == c) &&
                      ((fflags_d[c] != fflags_q[c]) || (frm_d[c] != frm_q[c])));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dirty_q <= '0;
    else     dirty_q <= dirty_set | (dirty_q & ~fs_clean);
  end

  assign fs_dirty = dirty_q;
`endif

endmodule

// File: tb/tb_fpu_csr_ctx.sv
// Directed bench: stimulus pushes expected CSR responses / resolved rm into queues, negedge monitors pop and compare.
module tb_fpu_csr_ctx;
  import fpu_csr_pkg::*;

  localparam int NUM_CTX   = 3;
  localparam int NUM_PORTS = 2;
  localparam int XLEN      = 32;
  localparam int CTX_W     = 2;

  typedef struct packed { logic [31:0] rdata; logic ill; } rsp_t;
  typedef struct packed { logic [2:0] rm; logic ill; } rm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_PORTS-1:0]        fpu_done = '0;
  logic [NUM_PORTS*CTX_W-1:0]  fpu_done_ctx = '0;
  logic [NUM_PORTS*5-1:0]      fpu_done_flags = '0;
  logic                        fpu_issue_valid = 1'b0;
  logic [CTX_W-1:0]            fpu_issue_ctx = '0;
  logic [2:0]                  fpu_issue_rm = '0;
  logic                        fpu_rm_valid;
  logic [2:0]                  fpu_rm;
  logic                        fpu_rm_illegal;
`ifdef FPU_CSR_DIRTY_EN
  logic [NUM_CTX-1:0]          fs_dirty;
  logic [NUM_CTX-1:0]          fs_clean = '0;
`endif

  int checks = 0;
  int errors = 0;
  rsp_t rsp_q[$];
  rm_t  rm_q[$];

  fpu_csr_ctx_if #(.CTX_W(CTX_W), .XLEN(XLEN)) csr();

  fpu_csr_ctx #(.NUM_CTX(NUM_CTX), .NUM_PORTS(NUM_PORTS), .XLEN(XLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .csr             (csr),
    .fpu_done        (fpu_done),
    .fpu_done_ctx    (fpu_done_ctx),
    .fpu_done_flags  (fpu_done_flags),
    .fpu_issue_valid (fpu_issue_valid),
    .fpu_issue_ctx   (fpu_issue_ctx),
    .fpu_issue_rm    (fpu_issue_rm),
`ifdef FPU_CSR_DIRTY_EN
    .fs_dirty        (fs_dirty),
    .fs_clean        (fs_clean),
`endif
    .fpu_rm_valid    (fpu_rm_valid),
    .fpu_rm          (fpu_rm),
    .fpu_rm_illegal  (fpu_rm_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && csr.csr_rsp_valid && csr.csr_rsp_ready) begin
      if (rsp_q.size() == 0) begin
        chk(1'b0, "unexpected_rsp", csr.csr_rsp_rdata, 32'h0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk(csr.csr_rsp_rdata === e.rdata, "rsp_rdata", csr.csr_rsp_rdata, e.rdata);
        chk(csr.csr_rsp_illegal === e.ill, "rsp_illegal", 32'(csr.csr_rsp_illegal), 32'(e.ill));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && fpu_rm_valid) begin
      if (rm_q.size() == 0) begin
        chk(1'b0, "unexpected_rm", 32'(fpu_rm), 32'h0);
      end else begin
        rm_t e;
        e = rm_q.pop_front();
        chk(fpu_rm === e.rm, "fpu_rm", 32'(fpu_rm), 32'(e.rm));
        chk(fpu_rm_illegal === e.ill, "fpu_rm_illegal", 32'(fpu_rm_illegal), 32'(e.ill));
      end
    end
  end

  task automatic csr_req_full(input bit push, input logic [CTX_W-1:0] ctx, input logic [1:0] op,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_ill,
                              input logic [NUM_PORTS-1:0] d, input logic [NUM_PORTS*CTX_W-1:0] dctx,
                              input logic [NUM_PORTS*5-1:0] dflags);
    int n = 0;
    @(negedge clk);
    while (!csr.csr_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!csr.csr_req_ready) chk(1'b0, "req_ready_timeout", 32'(csr.csr_req_ready), 32'h1);
    if (push) rsp_q.push_back('{rdata: exp_rdata, ill: exp_ill});
    csr.csr_req_valid = 1'b1;
    csr.csr_ctx       = ctx;
    csr.csr_op        = op;
    csr.csr_addr      = addr;
    csr.csr_wdata     = wdata;
    fpu_done          = d;
    fpu_done_ctx      = dctx;
    fpu_done_flags    = dflags;
    @(posedge clk);
    #1;
    csr.csr_req_valid = 1'b0;
    fpu_done          = '0;
    @(negedge clk);
    chk(csr.csr_rsp_valid === 1'b1, "rsp_latency", 32'(csr.csr_rsp_valid), 32'h1);
  endtask

  task automatic req(input logic [CTX_W-1:0] ctx, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_ill);
    csr_req_full(1'b1, ctx, op, addr, wdata, exp_rdata, exp_ill, '0, '0, '0);
  endtask

  task automatic issue(input logic [CTX_W-1:0] ctx, input logic [2:0] rm,
                       input logic [2:0] exp_rm, input logic exp_ill);
    @(posedge clk);
    #1;
    rm_q.push_back('{rm: exp_rm, ill: exp_ill});
    fpu_issue_valid = 1'b1;
    fpu_issue_ctx   = ctx;
    fpu_issue_rm    = rm;
    @(posedge clk);
    #1;
    fpu_issue_valid = 1'b0;
  endtask

  task automatic retire(input logic [NUM_PORTS-1:0] d, input logic [NUM_PORTS*CTX_W-1:0] dctx,
                        input logic [NUM_PORTS*5-1:0] dflags);
    @(posedge clk);
    #1;
    fpu_done       = d;
    fpu_done_ctx   = dctx;
    fpu_done_flags = dflags;
    @(posedge clk);
    #1;
    fpu_done = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    csr.csr_req_valid = 1'b0;
    csr.csr_ctx       = '0;
    csr.csr_op        = '0;
    csr.csr_addr      = '0;
    csr.csr_wdata     = '0;
    csr.csr_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(csr.csr_req_ready === 1'b1, "reset_req_ready", 32'(csr.csr_req_ready), 32'h1);
    chk(csr.csr_rsp_valid === 1'b0, "reset_rsp_valid", 32'(csr.csr_rsp_valid), 32'h0);
    chk(csr.csr_rsp_rdata === 32'h0, "reset_rsp_rdata", csr.csr_rsp_rdata, 32'h0);
    chk(csr.csr_rsp_illegal === 1'b0, "reset_rsp_illegal", 32'(csr.csr_rsp_illegal), 32'h0);
    chk(fpu_rm_valid === 1'b0, "reset_rm_valid", 32'(fpu_rm_valid), 32'h0);
    chk(fpu_rm === 3'b000, "reset_rm", 32'(fpu_rm), 32'h0);
    chk(fpu_rm_illegal === 1'b0, "reset_rm_illegal", 32'(fpu_rm_illegal), 32'h0);

    req(2'd0, OP_READ, CSR_FCSR, 32'h0, 32'h0, 1'b0);
    req(2'd1, OP_RW, CSR_FCSR, 32'hE5, 32'h0, 1'b0);
    req(2'd1, OP_READ, CSR_FRM, 32'h0, 32'h7, 1'b0);
    req(2'd1, OP_READ, CSR_FFLAGS, 32'h0, 32'h5, 1'b0);
    req(2'd0, OP_READ, CSR_FCSR, 32'h0, 32'h0, 1'b0);
    req(2'd1, OP_READ, CSR_FCSR, 32'h0, 32'hE5, 1'b0);

    // RS on ctx0 fflags with a same-cycle retire of NV on ctx0
    csr_req_full(1'b1, 2'd0, OP_RS, CSR_FFLAGS, 32'h03, 32'h0, 1'b0, 2'b01, 4'b0000, 10'h010);
    req(2'd0, OP_READ, CSR_FFLAGS, 32'h0, 32'h13, 1'b0);

    req(2'd1, OP_RW, CSR_FRM, 32'h3, 32'h7, 1'b0);
    issue(2'd1, 3'b111, 3'd3, 1'b0);
    req(2'd1, OP_RW, CSR_FRM, 32'h6, 32'h3, 1'b0);
    issue(2'd1, 3'b111, 3'd0, 1'b1);
    issue(2'd0, 3'b010, 3'd2, 1'b0);
    issue(2'd0, 3'b101, 3'd0, 1'b1);
    issue(2'd3, 3'b111, 3'd0, 1'b1);
    issue(2'd0, 3'b111, 3'd0, 1'b0);

    // Illegal address with response backpressure held for several cycles
    @(posedge clk);
    #1 csr.csr_rsp_ready = 1'b0;
    req(2'd0, OP_RW, 12'h004, 32'hFF, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(csr.csr_rsp_valid === 1'b1, "hold_rsp_valid", 32'(csr.csr_rsp_valid), 32'h1);
      chk(csr.csr_rsp_rdata === 32'h0, "hold_rsp_rdata", csr.csr_rsp_rdata, 32'h0);
      chk(csr.csr_rsp_illegal === 1'b1, "hold_rsp_illegal", 32'(csr.csr_rsp_illegal), 32'h1);
      chk(csr.csr_req_ready === 1'b0, "hold_req_ready", 32'(csr.csr_req_ready), 32'h0);
    end
    @(posedge clk);
    #1 csr.csr_rsp_ready = 1'b1;
    req(2'd3, OP_RW, CSR_FCSR, 32'hFF, 32'h0, 1'b1);
    req(2'd0, OP_READ, CSR_FFLAGS, 32'h0, 32'h13, 1'b0);

    req(2'd0, OP_RW, CSR_FFLAGS, 32'h0, 32'h13, 1'b0);
    retire(2'b11, 4'b0000, 10'h101);
    retire(2'b01, 4'b0011, 10'h01F);
    req(2'd0, OP_READ, CSR_FFLAGS, 32'h0, 32'h09, 1'b0);
    req(2'd2, OP_READ, CSR_FFLAGS, 32'h0, 32'h00, 1'b0);
    req(2'd0, OP_RC, CSR_FFLAGS, 32'h01, 32'h09, 1'b0);
    req(2'd0, OP_READ, CSR_FFLAGS, 32'h0, 32'h08, 1'b0);
    req(2'd2, OP_RS, CSR_FCSR, 32'hFFFF_FF00, 32'h0, 1'b0);
    req(2'd2, OP_READ, CSR_FCSR, 32'h0, 32'h00, 1'b0);
    req(2'd1, OP_READ, CSR_FRM, 32'hFF, 32'h6, 1'b0);
    req(2'd1, OP_READ, CSR_FCSR, 32'h0, 32'hC5, 1'b0);

    // Reset while a response is pending drops it and clears all state
    @(posedge clk);
    #1 csr.csr_rsp_ready = 1'b0;
    csr_req_full(1'b0, 2'd1, OP_READ, CSR_FCSR, 32'h0, 32'h0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(csr.csr_rsp_valid === 1'b0, "rst_rsp_valid", 32'(csr.csr_rsp_valid), 32'h0);
    chk(csr.csr_req_ready === 1'b1, "rst_req_ready", 32'(csr.csr_req_ready), 32'h1);
    chk(csr.csr_rsp_rdata === 32'h0, "rst_rsp_rdata", csr.csr_rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    csr.csr_rsp_ready = 1'b1;
    req(2'd1, OP_READ, CSR_FCSR, 32'h0, 32'h0, 1'b0);
    req(2'd0, OP_READ, CSR_FFLAGS, 32'h0, 32'h0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(rsp_q.size() == 0, "rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    chk(rm_q.size() == 0, "rm_queue_drained", 32'(rm_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
